// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding and default pattern for the serial sequence blocks
package seq_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10,
    DONE  = 2'b11
  } seq_state_e;
  localparam logic [3:0] SEQ_DEFAULT_PATTERN = 4'b1101;
endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that saturates at zero and flags it
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt_q, cnt_d;
  // load wins over decrement; decrement stops at zero so the count never wraps
  always_comb cnt_d = load ? load_val : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  // count register
  always_ff @(posedge Clock) begin
    if (Reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign zero = cnt_q == '0;
endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: captures a pattern on start and shifts it out MSB-first with repeats and gaps
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(SEQ_DEFAULT_PATTERN)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             start,
  input  logic             use_default,
  input  logic [WIDTH-1:0] pattern_in,
  input  logic [3:0]       repeat_cnt,
  input  logic [3:0]       gap,
  output logic             w,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);
  localparam int IW = $clog2(WIDTH);
  seq_state_e state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0] rep_q, rep_d, gap_len_q, gap_len_d;
  logic bit_load, bit_dec, bit_zero, gap_load, gap_dec, gap_zero;
  seq_down_counter #(.W(IW)) u_bit_idx (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (bit_load),
    .load_val (IW'(WIDTH - 1)),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );
  seq_down_counter #(.W(4)) u_gap_ctr (
    .Clock    (Clock),
    .Reset    (Reset),
    .load     (gap_load),
    .load_val (gap_len_q - 4'd1),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );
  // next state: a full rotation per frame leaves shreg holding the original pattern for the next repeat
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    bit_load  = 1'b0;
    bit_dec   = 1'b0;
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        shreg_d   = use_default ? DEFAULT_PATTERN : pattern_in;
        rep_d     = repeat_cnt;
        gap_len_d = gap;
        bit_load  = 1'b1;
        state_d   = SHIFT;
      end
      SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
        bit_dec = 1'b1;
        if (bit_zero) begin
          if (rep_q == 4'd0) state_d = DONE;
          else if (gap_len_q == 4'd0) begin
            rep_d    = rep_q - 4'd1;
            bit_load = 1'b1;
          end else begin
            gap_load = 1'b1;
            state_d  = GAP;
          end
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        if (gap_zero) begin
          rep_d    = rep_q - 4'd1;
          bit_load = 1'b1;
          state_d  = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state and capture registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
    end
  end
  assign w         = (state_q == SHIFT) && shreg_q[WIDTH-1];
  assign bit_valid = state_q == SHIFT;
  assign busy      = (state_q == SHIFT) || (state_q == GAP);
  assign done      = state_q == DONE;
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter for the bit-serial sequence interface. It captures a WIDTH-bit pattern on `start` and shifts it out MSB-first on `w`, one bit per clock. A programmable repeat count and inter-frame zero gap let it drive the Moore sequence-detector blocks on the same serial line. It is the stimulus-side end of that interface and is usable in the lab top level and in loopback benches.

## Interface
- `WIDTH`, 4: pattern length in bits; legal range 2–16.
- `DEFAULT_PATTERN`, 4'b1101: pattern used when `use_default`=1.
- `Clock`  in  1  single system clock; all logic on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `use_default`  in  1  1: send `DEFAULT_PATTERN`; 0: send `pattern_in`.
- `pattern_in`  in  WIDTH  user pattern, captured when `start` is accepted.
- `repeat_cnt`  in  4  extra transmissions; total frames = `repeat_cnt`+1.
- `gap`  in  4  zero cycles inserted between frames; 0 = back-to-back.
- `w`  out  1  serial data.
- `bit_valid`  out  1  high while `w` carries a pattern bit.
- `busy`  out  1  high in SHIFT and GAP.
- `done`  out  1  one-cycle pulse after the last bit of the last frame.

## Operation
- Moore FSM. States: IDLE, SHIFT, GAP, DONE. All outputs are decoded from registered state, shift register, and counters only. No input reaches an output combinationally.
- IDLE: `w`=0, `bit_valid`=0, `busy`=0, `done`=0.
  - On `start`=1, capture the selected pattern into `shreg`, `repeat_cnt` into `rep_left`, and `gap` into `gap_len`.
  - Load `bit_idx`=WIDTH-1, then go to SHIFT.
- SHIFT: `w`=`shreg[WIDTH-1]`, `bit_valid`=1, `busy`=1.
  - Each cycle: rotate `shreg` left by 1 and decrement `bit_idx`.
  - At `bit_idx`=0:
    - If `rep_left`=0, go to DONE.
    - Else if `gap_len`=0, decrement `rep_left`, reload `bit_idx`, and stay in SHIFT. Rotation restores the original pattern.
    - Else load `gap_ctr`=`gap_len`-1 and go to GAP.
- GAP: `w`=0, `bit_valid`=0, `busy`=1.
  - Decrement `gap_ctr`.
  - At 0: decrement `rep_left`, reload `bit_idx`, and go to SHIFT.
- DONE: `done`=1, `busy`=0, `w`=0, `bit_valid`=0. Go to IDLE unconditionally.
  - `start` in DONE is ignored; the earliest new start is the following cycle.
- `start` outside IDLE is ignored. No queuing.
- `pattern_in`, `use_default`, `repeat_cnt`, and `gap` changing mid-transfer have no effect; only values captured at accept are used.
- Unused state encodings go to IDLE.

## Timing
- Reset values: state=IDLE, `w`=0, `bit_valid`=0, `busy`=0, `done`=0, `shreg`=0, all counters 0.
- Reset during any state takes priority over everything. Outputs are idle values from the next cycle, and no `done` is issued.
- Latency: `start` sampled at edge k means the MSB appears on `w` during cycle k+1.
- `busy` duration = (R+1)·WIDTH + R·G cycles, where R=`repeat_cnt` and G=`gap`.
- `done` is high in the cycle immediately after the last pattern bit. `busy` drops in that same cycle.
- Back-to-back operation: a new `start` in the cycle after `done` is accepted. Minimum frame-to-frame spacing between separate requests is 2 idle cycles (DONE, IDLE).
- Counter widths: `bit_idx` is clog2(WIDTH) bits; `rep_left` and `gap_ctr` are 4 bits. No wrap-around can occur because every decrement is guarded by its zero test.

## Structure
- Package `seq_pkg`:
  - state typedef/encoding (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10, DONE=2'b11);
  - the 4'b1101 default pattern constant, shared with the detector blocks.
- Sub-module `seq_down_counter`:
  - parameterised width;
  - inputs: `load`, `load_val`, `dec`;
  - output: `zero` flag.
- Instantiated twice in `seq_pattern_tx`: once for `bit_idx`, once for `gap_ctr`. `rep_left` stays inline.

## Test plan
- Default frame: `use_default`=1, `repeat_cnt`=0, `gap`=0, one-cycle `start` → `w`=1,1,0,1 on cycles k+1..k+4 with `bit_valid`=1; `done`=1 at k+5; `busy` high for exactly 4 cycles.
- Repeat with gap: `pattern_in`=4'b1011, `use_default`=0, `repeat_cnt`=2, `gap`=2 → `w`=1011 00 1011 00 1011; `busy`=16 cycles; a single `done` pulse.
- Back-to-back repeats: default pattern, `repeat_cnt`=1, `gap`=0 → `w`=11011101 over 8 consecutive cycles. In loopback, the detector output `z` pulses once per frame.
- Ignored inputs: assert `start` and change `pattern_in` during SHIFT and during DONE → the transmitted sequence and bit count are unchanged, and there is no second frame.
- Reset mid-frame: assert `Reset` on the 3rd bit → next cycle `w`=0, `busy`=0, no `done`. A `start` two cycles later sends a full, correct frame.
- Reset values: hold `Reset` for 3 cycles with `start`=1 → all outputs 0 throughout. The first accepted start comes after `Reset` deasserts.
